// File: rtl/timekeeper_pkg.sv
// Shared widths, field encoding and wrap helpers for the front-panel time-of-day counter.
package timekeeper_pkg;

    localparam int unsigned HOUR_W  = 5;
    localparam int unsigned MIN_W   = 6;
    localparam int unsigned SEC_W   = 6;
    localparam int unsigned BIN_W   = 6;
    localparam int unsigned BCD_W   = 8;
    localparam int unsigned FIELD_W = 2;

    localparam int unsigned MAX_SEC        = 59;
    localparam int unsigned MAX_MIN        = 59;
    localparam int unsigned MAX_HOUR       = 23;
    localparam int unsigned HOURS_HALF_DAY = 12;

    typedef enum logic [FIELD_W-1:0] {
        FIELD_MIN  = 2'd0,
        FIELD_HOUR = 2'd1,
        FIELD_SEC  = 2'd2
    } field_e;

    typedef struct packed {
        logic [HOUR_W-1:0] hour;
        logic [MIN_W-1:0]  minute;
        logic [SEC_W-1:0]  second;
    } tod_t;

    // One step up or down with wrap between 0 and max_v; out-of-range values recover to a bound.
    function automatic logic [BIN_W-1:0] wrap_step(input logic [BIN_W-1:0] v,
                                                   input logic [BIN_W-1:0] max_v,
                                                   input logic             up);
        logic [BIN_W-1:0] r;
        if (up) begin
            r = (v >= max_v) ? '0 : v + BIN_W'(1);
        end else begin
            r = (v == '0 || v > max_v) ? max_v : v - BIN_W'(1);
        end
        return r;
    endfunction

    function automatic field_e next_field(input field_e f);
        field_e r;
        case (f)
            FIELD_MIN:  r = FIELD_HOUR;
            FIELD_HOUR: r = FIELD_SEC;
            default:    r = FIELD_MIN;
        endcase
        return r;
    endfunction

    // 24 h internal hour to 12 h display hour: midnight/noon show as 12.
    function automatic logic [HOUR_W-1:0] hour_12h(input logic [HOUR_W-1:0] h);
        logic [HOUR_W-1:0] r;
        if (h == '0) begin
            r = HOUR_W'(HOURS_HALF_DAY);
        end else if (h > HOUR_W'(HOURS_HALF_DAY)) begin
            r = h - HOUR_W'(HOURS_HALF_DAY);
        end else begin
            r = h;
        end
        return r;
    endfunction

endpackage

// File: rtl/timekeeper_bin2bcd60.sv
// Combinational binary (0-59) to two-digit packed BCD for the tube drivers.
module bin2bcd60
    import timekeeper_pkg::*;
(
    input  logic [BIN_W-1:0] bin,
    output logic [BCD_W-1:0] bcd
);

    logic [3:0] tens;
    logic [3:0] ones;

    // Range compare instead of a divider: only six tens values exist.
    always_comb begin
        tens = 4'd0;
        ones = 4'(bin);
        if (bin >= 6'd50) begin
            tens = 4'd5;
            ones = 4'(bin - 6'd50);
        end else if (bin >= 6'd40) begin
            tens = 4'd4;
            ones = 4'(bin - 6'd40);
        end else if (bin >= 6'd30) begin
            tens = 4'd3;
            ones = 4'(bin - 6'd30);
        end else if (bin >= 6'd20) begin
            tens = 4'd2;
            ones = 4'(bin - 6'd20);
        end else if (bin >= 6'd10) begin
            tens = 4'd1;
            ones = 4'(bin - 6'd10);
        end
        bcd = {tens, ones};
    end

endmodule

// File: rtl/timekeeper.sv
// Time-of-day counter with key editing, 12/24 h display mapping and 1 Hz / day-wrap pulses.
module timekeeper
    import timekeeper_pkg::*;
#(
    parameter int unsigned TICKS_PER_SEC = 100_000_000
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               power_state,
    input  logic               set_mode,
    input  logic               select_key,
    input  logic               increase_key,
    input  logic               decrease_key,
    input  logic               mode_12h,
    output logic [BCD_W-1:0]   hour_bcd,
    output logic [BCD_W-1:0]   minute_bcd,
    output logic [BCD_W-1:0]   second_bcd,
    output logic               pm,
    output logic [FIELD_W-1:0] set_field,
    output logic               tick_1hz,
    output logic               day_wrap
);

    localparam int unsigned     CNT_W    = $clog2(TICKS_PER_SEC);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICKS_PER_SEC - 1);

    logic [CNT_W-1:0] prescaler_q, prescaler_d;
    tod_t             tod_q, tod_d;
    field_e           field_q, field_d;
    logic             sel_prev_q, inc_prev_q, dec_prev_q;
    logic             tick_d, wrap_d, pm_d;

    logic running, editing;
    logic sel_edge, inc_edge, dec_edge;

    assign running  = power_state & ~set_mode;
    assign editing  = power_state & set_mode;
    assign sel_edge = select_key   & ~sel_prev_q;
    assign inc_edge = increase_key & ~inc_prev_q;
    assign dec_edge = decrease_key & ~dec_prev_q;

    // Next-state: run-mode counting with carries, edit-mode single-field steps, otherwise hold.
    always_comb begin
        prescaler_d = prescaler_q;
        tod_d       = tod_q;
        field_d     = field_q;
        tick_d      = 1'b0;
        wrap_d      = 1'b0;

        if (running) begin
            field_d = FIELD_MIN;
            if (prescaler_q == CNT_LAST) begin
                prescaler_d  = '0;
                tick_d       = 1'b1;
                tod_d.second = SEC_W'(wrap_step(BIN_W'(tod_q.second), BIN_W'(MAX_SEC), 1'b1));
                if (tod_q.second == SEC_W'(MAX_SEC)) begin
                    tod_d.minute = MIN_W'(wrap_step(BIN_W'(tod_q.minute), BIN_W'(MAX_MIN), 1'b1));
                    if (tod_q.minute == MIN_W'(MAX_MIN)) begin
                        tod_d.hour = HOUR_W'(wrap_step(BIN_W'(tod_q.hour), BIN_W'(MAX_HOUR), 1'b1));
                        wrap_d     = (tod_q.hour == HOUR_W'(MAX_HOUR));
                    end
                end
            end else begin
                prescaler_d = prescaler_q + CNT_W'(1);
            end
        end else if (editing) begin
            prescaler_d = '0;
            // Simultaneous increase and decrease cancel out.
            if (inc_edge != dec_edge) begin
                case (field_q)
                    FIELD_HOUR: tod_d.hour   = HOUR_W'(wrap_step(BIN_W'(tod_q.hour),
                                                                 BIN_W'(MAX_HOUR), inc_edge));
                    FIELD_SEC:  tod_d.second = SEC_W'(wrap_step(BIN_W'(tod_q.second),
                                                                BIN_W'(MAX_SEC), inc_edge));
                    default:    tod_d.minute = MIN_W'(wrap_step(BIN_W'(tod_q.minute),
                                                                BIN_W'(MAX_MIN), inc_edge));
                endcase
            end
            if (sel_edge) begin
                field_d = next_field(field_q);
            end
        end

        pm_d = (tod_d.hour >= HOUR_W'(HOURS_HALF_DAY));
    end

    // State register; key history keeps tracking while frozen so held keys never fire on power-up.
    always_ff @(posedge clk) begin
        if (reset) begin
            prescaler_q <= '0;
            tod_q       <= '0;
            field_q     <= FIELD_MIN;
            sel_prev_q  <= 1'b0;
            inc_prev_q  <= 1'b0;
            dec_prev_q  <= 1'b0;
            tick_1hz    <= 1'b0;
            day_wrap    <= 1'b0;
            pm          <= 1'b0;
        end else begin
            prescaler_q <= prescaler_d;
            tod_q       <= tod_d;
            field_q     <= field_d;
            sel_prev_q  <= select_key;
            inc_prev_q  <= increase_key;
            dec_prev_q  <= decrease_key;
            tick_1hz    <= tick_d;
            day_wrap    <= wrap_d;
            pm          <= pm_d;
        end
    end

    assign set_field = field_q;

    logic [HOUR_W-1:0] hour_disp;
    assign hour_disp = mode_12h ? hour_12h(tod_q.hour) : tod_q.hour;

    bin2bcd60 u_hour_bcd (
        .bin (BIN_W'(hour_disp)),
        .bcd (hour_bcd)
    );

    bin2bcd60 u_minute_bcd (
        .bin (BIN_W'(tod_q.minute)),
        .bcd (minute_bcd)
    );

    bin2bcd60 u_second_bcd (
        .bin (BIN_W'(tod_q.second)),
        .bcd (second_bcd)
    );

endmodule

// File: tb/tb_timekeeper.sv
// Bench for timekeeper: fixed vector table, directed corner sequences, then random traffic vs a seconds-of-day model.
module tb_timekeeper;

    localparam int TPS          = 4;
    localparam int SECS_PER_DAY = 86400;
    localparam int K_SEL        = 0;
    localparam int K_INC        = 1;
    localparam int K_DEC        = 2;

    logic       clk = 1'b0;
    logic       reset, power_state, set_mode;
    logic       select_key, increase_key, decrease_key, mode_12h;
    logic [7:0] hour_bcd, minute_bcd, second_bcd;
    logic       pm, tick_1hz, day_wrap;
    logic [1:0] set_field;

    int tests = 0;
    int fails = 0;

    // Reference model: whole time of day as one integer, plus cycles since the last second.
    int m_tod, m_phase, m_field;
    bit m_psel, m_pinc, m_pdec, m_tick, m_wrap;

    timekeeper #(.TICKS_PER_SEC(TPS)) dut (
        .clk          (clk),
        .reset        (reset),
        .power_state  (power_state),
        .set_mode     (set_mode),
        .select_key   (select_key),
        .increase_key (increase_key),
        .decrease_key (decrease_key),
        .mode_12h     (mode_12h),
        .hour_bcd     (hour_bcd),
        .minute_bcd   (minute_bcd),
        .second_bcd   (second_bcd),
        .pm           (pm),
        .set_field    (set_field),
        .tick_1hz     (tick_1hz),
        .day_wrap     (day_wrap)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst, pwr, set, sel, inc, dec, m12;
        logic [7:0] eh, em, es;
        logic       epm;
        logic [1:0] ef;
        logic       et, ew;
    } vec_t;

    vec_t vecs[17];

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s at %0t: got %02h expected %02h", name, $time, act, exp);
        end
    endtask

    function automatic logic [7:0] to_bcd(input int v);
        return 8'(((v / 10) << 4) | (v % 10));
    endfunction

    task automatic model_step();
        int h, m, s, d;
        bit se, ie, de;
        if (reset) begin
            m_tod = 0; m_phase = 0; m_field = 0;
            m_psel = 0; m_pinc = 0; m_pdec = 0;
            m_tick = 0; m_wrap = 0;
            return;
        end
        m_tick = 0;
        m_wrap = 0;
        se = select_key && !m_psel;
        ie = increase_key && !m_pinc;
        de = decrease_key && !m_pdec;
        if (power_state && !set_mode) begin
            m_field = 0;
            m_phase++;
            if (m_phase == TPS) begin
                m_phase = 0;
                m_tod   = (m_tod + 1) % SECS_PER_DAY;
                m_tick  = 1;
                m_wrap  = (m_tod == 0);
            end
        end else if (power_state) begin
            m_phase = 0;
            h = m_tod / 3600;
            m = (m_tod / 60) % 60;
            s = m_tod % 60;
            if (ie != de) begin
                d = ie ? 1 : -1;
                case (m_field)
                    0:       m = (m + d + 60) % 60;
                    1:       h = (h + d + 24) % 24;
                    default: s = (s + d + 60) % 60;
                endcase
                m_tod = h * 3600 + m * 60 + s;
            end
            if (se) m_field = (m_field + 1) % 3;
        end
        m_psel = select_key;
        m_pinc = increase_key;
        m_pdec = decrease_key;
    endtask

    task automatic check_model();
        int h, dh;
        h  = m_tod / 3600;
        dh = mode_12h ? ((h % 12 == 0) ? 12 : h % 12) : h;
        chk("hour_bcd",   hour_bcd,      to_bcd(dh));
        chk("minute_bcd", minute_bcd,    to_bcd((m_tod / 60) % 60));
        chk("second_bcd", second_bcd,    to_bcd(m_tod % 60));
        chk("pm",         8'(pm),        8'(h >= 12));
        chk("set_field",  8'(set_field), 8'(m_field));
        chk("tick_1hz",   8'(tick_1hz),  8'(m_tick));
        chk("day_wrap",   8'(day_wrap),  8'(m_wrap));
    endtask

    task automatic tick_edge();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic step();
        tick_edge();
        check_model();
    endtask

    task automatic set_key(input int k, input logic v);
        case (k)
            K_SEL:   select_key   = v;
            K_INC:   increase_key = v;
            default: decrease_key = v;
        endcase
    endtask

    task automatic press(input int k, input int n);
        for (int i = 0; i < n; i++) begin
            set_key(k, 1'b1);
            step();
            set_key(k, 1'b0);
            step();
        end
    endtask

    initial begin
        reset = 1'b1; power_state = 1'b0; set_mode = 1'b0; mode_12h = 1'b0;
        select_key = 1'b0; increase_key = 1'b0; decrease_key = 1'b0;

        //          rst   pwr   set   sel   inc   dec   m12    hour   min    sec    pm    fld    tick  wrap
        vecs[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 2'd0, 1'b0, 1'b0};
        vecs[1]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h12, 8'h00, 8'h00, 1'b0, 2'd0, 1'b0, 1'b0};
        vecs[2]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 2'd0, 1'b0, 1'b0};
        vecs[3]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 8'h59, 8'h00, 1'b0, 2'd0, 1'b0, 1'b0};
        vecs[4]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h59, 8'h00, 1'b0, 2'd0, 1'b0, 1'b0};
        vecs[5]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 2'd0, 1'b0, 1'b0};
        vecs[6]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 2'd0, 1'b0, 1'b0};
        vecs[7]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 2'd1, 1'b0, 1'b0};
        vecs[8]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h23, 8'h00, 8'h00, 1'b1, 2'd1, 1'b0, 1'b0};
        vecs[9]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'h11, 8'h00, 8'h00, 1'b1, 2'd1, 1'b0, 1'b0};
        vecs[10] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 8'h12, 8'h00, 8'h00, 1'b0, 2'd1, 1'b0, 1'b0};
        vecs[11] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 2'd2, 1'b0, 1'b0};
        vecs[12] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 8'h59, 1'b0, 2'd2, 1'b0, 1'b0};
        vecs[13] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 2'd0, 1'b0, 1'b0};
        vecs[14] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 2'd0, 1'b0, 1'b0};
        vecs[15] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 2'd0, 1'b0, 1'b0};
        vecs[16] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 2'd0, 1'b0, 1'b0};

        for (int i = 0; i < 17; i++) begin
            reset = vecs[i].rst; power_state = vecs[i].pwr; set_mode = vecs[i].set;
            select_key = vecs[i].sel; increase_key = vecs[i].inc; decrease_key = vecs[i].dec;
            mode_12h = vecs[i].m12;
            tick_edge();
            chk("vec_hour",  hour_bcd,      vecs[i].eh);
            chk("vec_min",   minute_bcd,    vecs[i].em);
            chk("vec_sec",   second_bcd,    vecs[i].es);
            chk("vec_pm",    8'(pm),        8'(vecs[i].epm));
            chk("vec_field", 8'(set_field), 8'(vecs[i].ef));
            chk("vec_tick",  8'(tick_1hz),  8'(vecs[i].et));
            chk("vec_wrap",  8'(day_wrap),  8'(vecs[i].ew));
        end
        select_key = 1'b0; increase_key = 1'b0; decrease_key = 1'b0; mode_12h = 1'b0;

        // First second after reset: tick on the 4th run cycle, for exactly one cycle.
        reset = 1'b1; step();
        reset = 1'b0; power_state = 1'b1; set_mode = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("run_no_tick", 8'(tick_1hz), 8'h00);
        end
        step();
        chk("run_sec1", second_bcd, 8'h01);
        chk("run_tick", 8'(tick_1hz), 8'h01);
        step();
        chk("run_tick_once", 8'(tick_1hz), 8'h00);

        // Preload 23:59:59 by editing, then leave edit and expect the day to roll 4 cycles later.
        set_mode = 1'b1; step();
        press(K_DEC, 1);
        press(K_SEL, 1);
        press(K_DEC, 1);
        press(K_SEL, 1);
        press(K_DEC, 2);
        chk("pre_hour", hour_bcd, 8'h23);
        chk("pre_min", minute_bcd, 8'h59);
        chk("pre_sec", second_bcd, 8'h59);
        set_mode = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("resume_no_tick", 8'(tick_1hz), 8'h00);
        end
        step();
        chk("wrap_hour", hour_bcd, 8'h00);
        chk("wrap_min", minute_bcd, 8'h00);
        chk("wrap_sec", second_bcd, 8'h00);
        chk("wrap_tick", 8'(tick_1hz), 8'h01);
        chk("wrap_pulse", 8'(day_wrap), 8'h01);
        step();
        chk("wrap_pulse_end", 8'(day_wrap), 8'h00);

        // Noon and 13:00 in 12 h display.
        set_mode = 1'b1; step();
        press(K_SEL, 1);
        press(K_INC, 12);
        mode_12h = 1'b1; step();
        chk("h12_noon", hour_bcd, 8'h12);
        chk("h12_noon_pm", 8'(pm), 8'h01);
        press(K_INC, 1);
        chk("h12_13", hour_bcd, 8'h01);
        chk("h12_13_pm", 8'(pm), 8'h01);
        mode_12h = 1'b0; step();
        chk("h24_13", hour_bcd, 8'h13);

        // Held key counts once.
        increase_key = 1'b1;
        for (int i = 0; i < 10; i++) step();
        chk("hold_inc", hour_bcd, 8'h14);
        increase_key = 1'b0; step();

        // Frozen with keys bouncing; then power-up with increase held must not fire.
        power_state = 1'b0;
        for (int i = 0; i < 20; i++) begin
            select_key = 1'($urandom_range(0, 1));
            increase_key = 1'($urandom_range(0, 1));
            decrease_key = 1'($urandom_range(0, 1));
            step();
            chk("frz_hour", hour_bcd, 8'h14);
            chk("frz_min", minute_bcd, 8'h00);
            chk("frz_field", 8'(set_field), 8'h01);
        end
        select_key = 1'b0; decrease_key = 1'b0; increase_key = 1'b1; step();
        power_state = 1'b1; step();
        chk("pwrup_held", hour_bcd, 8'h14);
        increase_key = 1'b0; step();

        // Reset in the middle of editing 07:30:15 at the hour field.
        reset = 1'b1; step();
        reset = 1'b0; step();
        press(K_INC, 30);
        press(K_SEL, 1);
        press(K_INC, 7);
        press(K_SEL, 1);
        press(K_INC, 15);
        press(K_SEL, 2);
        chk("mid_hour", hour_bcd, 8'h07);
        chk("mid_min", minute_bcd, 8'h30);
        chk("mid_sec", second_bcd, 8'h15);
        chk("mid_field", 8'(set_field), 8'h01);
        reset = 1'b1; step();
        chk("rst_hour", hour_bcd, 8'h00);
        chk("rst_min", minute_bcd, 8'h00);
        chk("rst_sec", second_bcd, 8'h00);
        chk("rst_field", 8'(set_field), 8'h00);
        chk("rst_tick", 8'(tick_1hz), 8'h00);
        chk("rst_wrap", 8'(day_wrap), 8'h00);
        reset = 1'b0;

        // Random traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            reset        = ($urandom_range(0, 499) == 0);
            power_state  = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 59) == 0) set_mode = ~set_mode;
            if ($urandom_range(0, 19) == 0) mode_12h = ~mode_12h;
            select_key   = ($urandom_range(0, 3) == 0);
            increase_key = ($urandom_range(0, 3) == 0);
            decrease_key = ($urandom_range(0, 3) == 0);
            step();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
